// File: rtl/keypad_num_entry.sv
// keypad_num_entry: scans and debounces a 4x4 keypad, turning decimal key entry
// into an 8-bit value with Clear (*) and Enter (#).
module keypad_num_entry #(
    parameter logic [15:0] SCAN_TICKS = 16'd50000,
    parameter logic [3:0]  DEB_SCANS  = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [7:0] num,
    output logic [7:0] value,
    output logic       entered,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       overflow
);
    // Key codes indexed by {row, col}, four bits per entry.
    localparam logic [63:0] KEYMAP = {4'hD, 4'hF, 4'h0, 4'hE, 4'hC, 4'h9, 4'h8, 4'h7,
                                      4'hB, 4'h6, 4'h5, 4'h4, 4'hA, 4'h3, 4'h2, 4'h1};
    logic [3:0]  row_s1_q, row_s2_q;
    logic [15:0] dwell_q, dwell_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [1:0]  hits_q, hits_d;
    logic [3:0]  code_acc_q, code_acc_d;
    logic        prev_valid_q, prev_valid_d;
    logic [3:0]  prev_code_q, prev_code_d;
    logic [3:0]  stable_q, stable_d;
    logic        latched_q, latched_d;
    logic [7:0]  num_q, num_d, value_q, value_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        entered_q, entered_d, key_valid_q, key_valid_d, overflow_q, overflow_d;
    logic [3:0]  lows, cur_code, res_code, stable_next;
    logic [2:0]  col_cnt, tot;
    logic [1:0]  row_idx;
    logic [11:0] t;
    logic        sample, scan_end, res_valid, same, accept, is_digit;

    always_comb begin
        lows        = ~row_s2_q;
        col_cnt     = {2'b0, lows[0]} + {2'b0, lows[1]} + {2'b0, lows[2]} + {2'b0, lows[3]};
        row_idx     = lows[0] ? 2'd0 : lows[1] ? 2'd1 : lows[2] ? 2'd2 : 2'd3;
        cur_code    = KEYMAP[{row_idx, col_idx_q, 2'b00} +: 4];
        sample      = dwell_q == SCAN_TICKS - 16'd1;
        scan_end    = sample && col_idx_q == 2'd3;
        tot         = {1'b0, hits_q} + col_cnt;
        res_valid   = tot == 3'd1;
        res_code    = col_cnt == 3'd1 ? cur_code : code_acc_q;
        same        = res_valid == prev_valid_q && (!res_valid || res_code == prev_code_q);
        stable_next = !same ? 4'd1 : stable_q >= DEB_SCANS ? DEB_SCANS : stable_q + 4'd1;
        accept      = scan_end && res_valid && stable_next == DEB_SCANS && !latched_q;
        dwell_d     = sample ? 16'd0 : dwell_q + 16'd1;
        col_idx_d   = sample ? col_idx_q + 2'd1 : col_idx_q;
        // Hit count saturates at 2: anything beyond one key is a multi-press.
        hits_d      = scan_end ? 2'd0 : sample ? (tot >= 3'd2 ? 2'd2 : tot[1:0]) : hits_q;
        code_acc_d  = scan_end ? 4'd0 : (sample && col_cnt == 3'd1) ? cur_code : code_acc_q;
        prev_valid_d = scan_end ? res_valid : prev_valid_q;
        prev_code_d = scan_end ? res_code : prev_code_q;
        stable_d    = scan_end ? stable_next : stable_q;
        latched_d   = accept ? 1'b1 :
                      (scan_end && !res_valid && stable_next == DEB_SCANS) ? 1'b0 : latched_q;
        t           = {4'b0, num_q} * 12'd10 + {8'b0, res_code};
        is_digit    = res_code <= 4'd9;
        num_d       = !accept ? num_q :
                      is_digit ? (t <= 12'd255 ? t[7:0] : num_q) :
                      (res_code == 4'hE || res_code == 4'hF) ? 8'd0 : num_q;
        value_d     = (accept && res_code == 4'hF) ? num_q : value_q;
        entered_d   = accept && res_code == 4'hF;
        key_valid_d = accept;
        key_code_d  = accept ? res_code : key_code_q;
        overflow_d  = accept && is_digit && t > 12'd255;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_s1_q     <= 4'hF;
            row_s2_q     <= 4'hF;
            dwell_q      <= 16'd0;
            col_idx_q    <= 2'd0;
            hits_q       <= 2'd0;
            code_acc_q   <= 4'd0;
            prev_valid_q <= 1'b0;
            prev_code_q  <= 4'd0;
            stable_q     <= 4'd0;
            latched_q    <= 1'b0;
            num_q        <= 8'd0;
            value_q      <= 8'd0;
            key_code_q   <= 4'd0;
            entered_q    <= 1'b0;
            key_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            row_s1_q     <= row;
            row_s2_q     <= row_s1_q;
            dwell_q      <= dwell_d;
            col_idx_q    <= col_idx_d;
            hits_q       <= hits_d;
            code_acc_q   <= code_acc_d;
            prev_valid_q <= prev_valid_d;
            prev_code_q  <= prev_code_d;
            stable_q     <= stable_d;
            latched_q    <= latched_d;
            num_q        <= num_d;
            value_q      <= value_d;
            key_code_q   <= key_code_d;
            entered_q    <= entered_d;
            key_valid_q  <= key_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign num       = num_q;
    assign value     = value_q;
    assign entered   = entered_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_keypad_num_entry.sv
// tb_keypad_num_entry: directed keypad sequences with a row model and a
// scoreboard of expected key events.
module tb_keypad_num_entry;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col, row;
    logic [7:0] num, value;
    logic       entered, key_valid, overflow;
    logic [3:0] key_code;
    logic [15:0] pressed = 16'h0;

    typedef struct {
        logic [3:0] code;
        logic [7:0] num;
        logic [7:0] value;
        logic       ent;
        logic       ov;
    } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0, kv_count = 0, exp_kv = 0;
    logic [7:0] m_num = 8'd0, m_value = 8'd0;

    keypad_num_entry #(.SCAN_TICKS(16'd4), .DEB_SCANS(4'd2)) dut (
        .clk(clk), .rst_n(rst_n), .col(col), .row(row), .num(num), .value(value),
        .entered(entered), .key_valid(key_valid), .key_code(key_code), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (key_valid || entered || overflow)) begin
            exp_t e;
            kv_count += int'(key_valid);
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("key_valid", 32'(key_valid), 32'd1);
                chk("key_code", 32'(key_code), 32'(e.code));
                chk("num", 32'(num), 32'(e.num));
                chk("value", 32'(value), 32'(e.value));
                chk("entered", 32'(entered), 32'(e.ent));
                chk("overflow", 32'(overflow), 32'(e.ov));
            end
        end
    end

    task automatic expect_key(input logic [3:0] code);
        exp_t e;
        int t;
        e.ent = 1'b0;
        e.ov = 1'b0;
        if (code <= 4'd9) begin
            t = int'(m_num) * 10 + int'(code);
            if (t <= 255) m_num = 8'(t);
            else e.ov = 1'b1;
        end else if (code == 4'hE) begin
            m_num = 8'd0;
        end else if (code == 4'hF) begin
            m_value = m_num;
            m_num = 8'd0;
            e.ent = 1'b1;
        end
        e.code = code;
        e.num = m_num;
        e.value = m_value;
        sb.push_back(e);
        exp_kv++;
    endtask

    task automatic press(input int r, input int c, input logic [3:0] code, input int scans);
        expect_key(code);
        pressed[r*4+c] = 1'b1;
        repeat (scans * 16) @(negedge clk);
        pressed = 16'h0;
        repeat (64) @(negedge clk);
        chk("num_after", 32'(num), 32'(m_num));
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_col(input logic [3:0] v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (col != v && n < 64);
        chk("col_wait", 32'(col), 32'(v));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_num", 32'(num), 32'd0);
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_key_code", 32'(key_code), 32'd0);
        chk("rst_entered", 32'(entered), 32'd0);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 20; i++) begin
            logic [3:0] ec;
            ec = ~(4'b0001 << ((i / 4) % 4));
            chk("col_rot", 32'(col), 32'(ec));
            @(negedge clk);
        end
        press(0, 1, 4'h2, 4);
        press(1, 1, 4'h5, 4);
        press(1, 1, 4'h5, 4);
        press(3, 2, 4'hF, 4);
        chk("kv_count_4", 32'(kv_count), 32'd4);
        chk("value_255", 32'(value), 32'd255);
        press(0, 1, 4'h2, 4);
        press(1, 1, 4'h5, 4);
        press(1, 2, 4'h6, 4);
        chk("num_25", 32'(num), 32'd25);
        press(3, 0, 4'hE, 4);
        pressed[8] = 1'b1;
        repeat (16) @(negedge clk);
        pressed = 16'h0;
        repeat (64) @(negedge clk);
        chk("glitch_kv", 32'(kv_count), 32'(exp_kv));
        chk("glitch_num", 32'(num), 32'd0);
        press(2, 0, 4'h7, 20);
        chk("num_7", 32'(num), 32'd7);
        pressed[0] = 1'b1;
        pressed[10] = 1'b1;
        repeat (80) @(negedge clk);
        chk("multi_kv", 32'(kv_count), 32'(exp_kv));
        expect_key(4'h1);
        pressed[10] = 1'b0;
        repeat (64) @(negedge clk);
        pressed = 16'h0;
        repeat (64) @(negedge clk);
        chk("single_1_kv", 32'(kv_count), 32'(exp_kv));
        chk("num_71", 32'(num), 32'd71);
        press(3, 0, 4'hE, 4);
        press(1, 0, 4'h4, 4);
        // Align to a scan start so acceptance of the next key lands on a known edge.
        wait_col(4'b0111);
        wait_col(4'b1110);
        pressed[1] = 1'b1;
        repeat (31) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        pressed = 16'h0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_num = 8'd0;
        m_value = 8'd0;
        chk("midrst_num", 32'(num), 32'd0);
        chk("midrst_value", 32'(value), 32'd0);
        chk("midrst_key_valid", 32'(key_valid), 32'd0);
        chk("midrst_col", 32'(col), 32'hE);
        repeat (64) @(negedge clk);
        chk("midrst_kv", 32'(kv_count), 32'(exp_kv));
        press(0, 2, 4'h3, 4);
        chk("num_3", 32'(num), 32'd3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
